// File: rtl/alu_result_fifo.sv
// First-word-fall-through result FIFO between the combinational ALU and its consumer.
// Optional sticky overflow flag: define ALU_RESULT_FIFO_STICKY_OVF_EN to enable it.
module alu_result_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_sum,
   input  logic                       in_carry,
   input  logic                       in_ovf,
   input  logic                       in_negf,
   input  logic                       in_zf,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_sum,
   output logic                       out_carry,
   output logic                       out_ovf,
   output logic                       out_negf,
   output logic                       out_zf,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   input  logic                       clr_sticky,
   output logic                       sticky_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = WIDTH + 4;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic [EW-1:0] w_in_word;
   logic [EW-1:0] w_head;

   // Handshake: a transfer fires on the rising edge when valid && ready on that side.
   // in_ready depends only on registered fill level (no bypass from out_ready), so a
   // full FIFO refuses writes even in a cycle where the head is being popped.
   assign w_full    = (r_count == DEPTH_C);
   assign w_empty   = (r_count == '0);
   assign w_push    = in_valid && !w_full;
   assign w_pop     = out_ready && !w_empty;
   assign w_in_word = {in_sum, in_carry, in_ovf, in_negf, in_zf};
   assign w_head    = r_mem[r_rd_ptr];

   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign full      = w_full;
   assign empty     = w_empty;
   assign count     = r_count;

   // Storage is deliberately not reset; the empty flag masks stale contents.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_in_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      out_sum   = '0;
      out_carry = 1'b0;
      out_ovf   = 1'b0;
      out_negf  = 1'b0;
      out_zf    = 1'b0;
      if (!w_empty) begin
         {out_sum, out_carry, out_ovf, out_negf, out_zf} = w_head;
      end
   end

`ifdef ALU_RESULT_FIFO_STICKY_OVF_EN
   logic r_sticky_ovf;

   // Set has priority over clear so an overflow in the clearing cycle is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky_ovf <= 1'b0;
      end else if (w_push && in_ovf) begin
         r_sticky_ovf <= 1'b1;
      end else if (clr_sticky) begin
         r_sticky_ovf <= 1'b0;
      end
   end

   assign sticky_ovf = r_sticky_ovf;
`else
   logic w_unused_clr;

   assign w_unused_clr = clr_sticky;
   assign sticky_ovf   = 1'b0;
`endif

endmodule
